// File: rtl/mmio_wb_master.sv
// mmio_wb_master
// Single-outstanding Wishbone classic master. Each accepted command on the
// valid/ready command stream becomes exactly one bus cycle toward the MMIO
// slave port. The result comes back as one response beat. A watchdog aborts
// any cycle that is not acknowledged within TIMEOUT cycles.
//
// Ports
//   CLK_I, RST_I           clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_we/addr/wdata      command payload
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     read data (0 for writes/errors), timeout flag
//   err_cnt                saturating count of watchdog aborts
//   ADDR_O, DAT_O, WE_O    bus address / write data / write enable
//   CYC_O, STB_O           bus cycle and strobe (always equal)
//   DAT_I, ACK_I           bus read data and slave acknowledge
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | ready for a command
// BUS   | bus cycle in flight, waiting for ACK_I or timeout
// RESP  | response held until rsp_ready
module mmio_wb_master #(
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] ADDR_O,
    output logic [DATA_W-1:0] DAT_O,
    input  logic [DATA_W-1:0] DAT_I,
    output logic              CYC_O,
    output logic              STB_O,
    output logic              WE_O,
    input  logic              ACK_I
);

    localparam int CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] WD_LAST = CW'(LAST_I);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     wd_cnt, wd_cnt_nx;
    logic              cmd_ready_nx;
    logic              rsp_valid_nx;
    logic [DATA_W-1:0] rsp_rdata_nx;
    logic              rsp_err_nx;
    logic [7:0]        err_cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] dat_nx;
    logic              cyc_nx;
    logic              we_nx;
    logic              wd_hit;

    // Watchdog fires on the last allowed cycle; TIMEOUT=0 never fires.
    assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= '0;
            ADDR_O    <= '0;
            DAT_O     <= '0;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
        end else begin
            state     <= state_nx;
            wd_cnt    <= wd_cnt_nx;
            cmd_ready <= cmd_ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_err   <= rsp_err_nx;
            err_cnt   <= err_cnt_nx;
            ADDR_O    <= addr_nx;
            DAT_O     <= dat_nx;
            CYC_O     <= cyc_nx;
            STB_O     <= cyc_nx;
            WE_O      <= we_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        wd_cnt_nx    = wd_cnt;
        rsp_valid_nx = rsp_valid;
        rsp_rdata_nx = rsp_rdata;
        rsp_err_nx   = rsp_err;
        err_cnt_nx   = err_cnt;
        addr_nx      = ADDR_O;
        dat_nx       = DAT_O;
        cyc_nx       = CYC_O;
        we_nx        = WE_O;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_nx   = cmd_addr;
                    dat_nx    = cmd_wdata;
                    we_nx     = cmd_we;
                    cyc_nx    = 1'b1;
                    wd_cnt_nx = '0;
                    state_nx  = BUS;
                end
            end
            BUS: begin
                // ACK wins over a watchdog hit in the same cycle.
                if (ACK_I) begin
                    cyc_nx       = 1'b0;
                    we_nx        = 1'b0;
                    rsp_rdata_nx = WE_O ? '0 : DAT_I;
                    rsp_err_nx   = 1'b0;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                end else if (wd_hit) begin
                    cyc_nx       = 1'b0;
                    we_nx        = 1'b0;
                    rsp_rdata_nx = '0;
                    rsp_err_nx   = 1'b1;
                    rsp_valid_nx = 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt_nx = err_cnt + 8'd1;
                    end
                    state_nx     = RESP;
                end else begin
                    wd_cnt_nx = wd_cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    rsp_err_nx   = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cyc_nx   = 1'b0;
                we_nx    = 1'b0;
            end
        endcase

        // cmd_ready is registered, so it reflects the state being entered.
        cmd_ready_nx = (state_nx == IDLE);
    end

endmodule

// File: tb/tb_mmio_wb_master.sv
module tb_mmio_wb_master;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [7:0]    err_cnt;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i = '0;
    logic          cyc_o, stb_o, we_o;
    logic          ack_i = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mmio_wb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_cnt(err_cnt),
        .ADDR_O(addr_o), .DAT_O(dat_o), .DAT_I(dat_i),
        .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command from IDLE and plays the slave: ACK on CYC cycle
    // index ack_at (0 = first), never if ack_at < 0. Returns right after the
    // edge that ends the bus cycle, with the response visible.
    task automatic do_cmd(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int ack_at,
                          input logic rdy, output int cyc_len,
                          output logic stable, output logic we_seen,
                          output logic rdy_seen);
        cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        rsp_ready = rdy;
        step();
        cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = ~addr; cmd_wdata = ~wd;
        cyc_len = 0; stable = 1'b1; we_seen = we_o; rdy_seen = cmd_ready;
        while (cyc_o && cyc_len < 40) begin
            if (addr_o !== addr || dat_o !== wd || we_o !== we || stb_o !== 1'b1)
                stable = 1'b0;
            ack_i = (cyc_len == ack_at);
            cyc_len++;
            step();
            ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
        total++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin bad++; $display("FAIL rst_bus_ctl got=%b exp=000", {cyc_o, stb_o, we_o}); end
        total++; if (addr_o !== '0 || dat_o !== '0 || rsp_rdata !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", addr_o, dat_o, rsp_rdata); end
    endtask

    task automatic test_read_zero_wait();
        int n; logic st, w, r;
        dat_i = 32'hDEADBEEF;
        do_cmd(1'b0, 21'h000010, 32'h0, 0, 1'b1, n, st, w, r);
        total++; if (n !== 1) begin bad++; $display("FAIL rd0_cyc_len got=%0d exp=1", n); end
        total++; if (w !== 1'b0 || st !== 1'b1) begin bad++; $display("FAIL rd0_bus got we=%b stable=%b exp we=0 stable=1", w, st); end
        total++; if (r !== 1'b0) begin bad++; $display("FAIL rd0_ready_in_bus got=%b exp=0", r); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd0_rsp_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd0_rdata got=%h exp=deadbeef", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rd0_err got=%b exp=0", rsp_err); end
        step();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rd0_cycle3 got valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_write_wait3();
        int n; logic st, w, r;
        dat_i = 32'h5555AAAA;
        do_cmd(1'b1, 21'h000020, 32'h000000A5, 3, 1'b1, n, st, w, r);
        total++; if (n !== 4) begin bad++; $display("FAIL wr3_cyc_len got=%0d exp=4", n); end
        total++; if (w !== 1'b1 || st !== 1'b1) begin bad++; $display("FAIL wr3_bus got we=%b stable=%b exp we=1 stable=1", w, st); end
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL wr3_rsp got v=%b d=%h e=%b exp 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        total++; if (we_o !== 1'b0 || cyc_o !== 1'b0) begin bad++; $display("FAIL wr3_bus_idle got we=%b cyc=%b exp 0/0", we_o, cyc_o); end
        step();
    endtask

    task automatic test_timeout();
        int n; logic st, w, r;
        dat_i = 32'hCAFEF00D;
        do_cmd(1'b0, 21'h000030, 32'h0, -1, 1'b1, n, st, w, r);
        total++; if (n !== TO) begin bad++; $display("FAIL to_cyc_len got=%0d exp=%0d", n, TO); end
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin bad++; $display("FAIL to_rsp got v=%b e=%b exp 1/1", rsp_valid, rsp_err); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", rsp_rdata); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL to_err_cnt got=%0d exp=1", err_cnt); end
        step();
        total++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL to_clear got v=%b e=%b exp 0/0", rsp_valid, rsp_err); end
    endtask

    task automatic test_ack_at_timeout();
        int n; logic st, w, r;
        dat_i = 32'h12345678;
        do_cmd(1'b0, 21'h000040, 32'h0, TO - 1, 1'b1, n, st, w, r);
        total++; if (n !== TO) begin bad++; $display("FAIL ackto_cyc_len got=%0d exp=%0d", n, TO); end
        total++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL ackto_rsp got e=%b d=%h exp 0/12345678", rsp_err, rsp_rdata); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL ackto_err_cnt got=%0d exp=1", err_cnt); end
        step();
    endtask

    task automatic test_backpressure();
        int n; logic st, w, r; logic ok;
        dat_i = 32'h0BADF00D;
        do_cmd(1'b0, 21'h000050, 32'h0, 1, 1'b0, n, st, w, r);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 21'h000060; cmd_wdata = '0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D || cmd_ready !== 1'b0 || cyc_o !== 1'b0)
                ok = 1'b0;
            step();
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_hold got v=%b d=%h rdy=%b cyc=%b", rsp_valid, rsp_rdata, cmd_ready, cyc_o); end
        rsp_ready = 1'b1;
        step();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc_o !== 1'b0) begin bad++; $display("FAIL bp_release got v=%b rdy=%b cyc=%b exp 0/1/0", rsp_valid, cmd_ready, cyc_o); end
        step();
        cmd_valid = 1'b0;
        total++; if (cyc_o !== 1'b1 || addr_o !== 21'h000060) begin bad++; $display("FAIL bp_next_cyc got cyc=%b addr=%h exp 1/000060", cyc_o, addr_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        int n; logic st, w, r;
        for (int i = 0; i < 100; i++) begin
            do_cmd(1'b0, 21'h000070, 32'h0, -1, 1'b1, n, st, w, r);
            step();
        end
        total++; if (err_cnt !== 8'd101) begin bad++; $display("FAIL sat_mid got=%0d exp=101", err_cnt); end
        for (int i = 0; i < 200; i++) begin
            do_cmd(1'b0, 21'h000070, 32'h0, -1, 1'b1, n, st, w, r);
            step();
        end
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_end got=%0d exp=255", err_cnt); end
    endtask

    task automatic test_reset_mid_bus();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 21'h000080; cmd_wdata = 32'h11;
        step();
        cmd_valid = 1'b0;
        step();
        total++; if (cyc_o !== 1'b1) begin bad++; $display("FAIL rmb_pre_cyc got=%b exp=1", cyc_o); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (cyc_o !== 1'b0 || stb_o !== 1'b0 || cmd_ready !== 1'b1 || err_cnt !== 8'd0) begin bad++; $display("FAIL rmb_async got cyc=%b stb=%b rdy=%b cnt=%0d exp 0/0/1/0", cyc_o, stb_o, cmd_ready, err_cnt); end
        step();
        rst_n = 1'b1;
        step();
        step();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc_o !== 1'b0) begin bad++; $display("FAIL rmb_after got v=%b rdy=%b cyc=%b exp 0/1/0", rsp_valid, cmd_ready, cyc_o); end
    endtask

    initial begin
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_read_zero_wait();
        test_write_wait3();
        test_timeout();
        test_ack_at_timeout();
        test_backpressure();
        test_saturate();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
